register_array_kv: RTL and testbench

- Parametrised successor to the cycled register-array priority queue.
- Each entry holds a sort key plus an opaque payload; priority direction (max-first or min-first) is selectable.
- Adds a ready handshake, an early-exit odd-even transposition sorter, an occupancy count and overflow/underflow flags.
- Sits between a scheduler front-end and the consumer; the head entry is always presented on the outputs.

---
 rtl/register_array_kv.sv | 190 +++++++++++++++++++
 tb/tb_register_array_kv.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_array_kv.sv
// Sorted key/payload priority queue: slot 0 always holds the head; dequeue takes one cycle,
// enqueue/replace run an odd-even transposition sort (2..QUEUE_SIZE+1 cycles) with o_ready low.
module register_array_kv #(
    parameter int QUEUE_SIZE    = 64,
    parameter int KEY_WIDTH     = 16,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int MAX_FIRST     = 1,
    parameter int ENQ_ENA       = 1,
    parameter int EARLY_EXIT    = 1
) (
    input  logic                               i_CLK,
    input  logic                               i_RST,
    input  logic                               i_wrt,
    input  logic                               i_read,
    input  logic [KEY_WIDTH-1:0]               i_key,
    input  logic [PAYLOAD_WIDTH-1:0]           i_payload,
    output logic                               o_ready,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]    o_count,
    output logic                               o_valid,
    output logic [KEY_WIDTH-1:0]               o_key,
    output logic [PAYLOAD_WIDTH-1:0]           o_payload,
    output logic                               o_overflow,
    output logic                               o_underflow
);

    localparam int CW = $clog2(QUEUE_SIZE+1);
    localparam int PW = $clog2(QUEUE_SIZE);
    localparam bit ENQ_ON = (ENQ_ENA != 0);

    typedef enum logic {S_IDLE, S_SORT} state_t;

    state_t                   state_q, state_d;
    logic                     phase_q, phase_d;
    logic [PW-1:0]            pcnt_q, pcnt_d;
    logic                     zero_q, zero_d;

    logic [KEY_WIDTH-1:0]     key_q [QUEUE_SIZE];
    logic [PAYLOAD_WIDTH-1:0] pay_q [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]    vld_q;
    logic [CW-1:0]            count_q;
    logic                     ovf_q, udf_q;

    logic [KEY_WIDTH-1:0]     key_s [QUEUE_SIZE];
    logic [PAYLOAD_WIDTH-1:0] pay_s [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]    vld_s;
    logic                     swap_any;
    logic                     sort_done;

    logic accept, full, empty;
    logic do_enq, do_ovf, do_deq, do_udf, do_rep;

    // Strict comparison keeps the sort stable, which gives the tie ordering for free.
    function automatic logic higher(input logic va, input logic [KEY_WIDTH-1:0] ka,
                                    input logic vb, input logic [KEY_WIDTH-1:0] kb);
        if (!va) return 1'b0;
        if (!vb) return 1'b1;
        if (MAX_FIRST != 0) return ka > kb;
        return ka < kb;
    endfunction

    assign accept = (state_q == S_IDLE);
    assign full   = (count_q == CW'(QUEUE_SIZE));
    assign empty  = (count_q == '0);

    assign do_enq = accept & i_wrt & ~i_read & ENQ_ON & ~full;
    assign do_ovf = accept & i_wrt & ~i_read & ENQ_ON & full;
    assign do_deq = accept & i_read & ~i_wrt & ~empty;
    assign do_udf = accept & i_read & ~i_wrt & empty;
    assign do_rep = accept & i_wrt & i_read;

    always_comb begin
        key_s    = key_q;
        pay_s    = pay_q;
        vld_s    = vld_q;
        swap_any = 1'b0;
        for (int i = 0; i < QUEUE_SIZE-1; i++) begin
            if ((i % 2) == int'(phase_q) &&
                higher(vld_q[i+1], key_q[i+1], vld_q[i], key_q[i])) begin
                key_s[i]   = key_q[i+1];
                key_s[i+1] = key_q[i];
                pay_s[i]   = pay_q[i+1];
                pay_s[i+1] = pay_q[i];
                vld_s[i]   = vld_q[i+1];
                vld_s[i+1] = vld_q[i];
                swap_any   = 1'b1;
            end
        end
    end

    assign sort_done = (EARLY_EXIT != 0) ? (!swap_any && zero_q)
                                         : (pcnt_q == PW'(QUEUE_SIZE-1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (do_enq || do_rep) begin
                    state_d = S_SORT;
                    phase_d = 1'b0;
                    pcnt_d  = '0;
                    zero_d  = 1'b0;
                end
            end
            S_SORT: begin
                phase_d = ~phase_q;
                pcnt_d  = pcnt_q + PW'(1);
                zero_d  = ~swap_any;
                if (sort_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            pcnt_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            zero_q  <= zero_d;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                key_q[i] <= '0;
                pay_q[i] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ovf_q <= do_ovf;
            udf_q <= do_udf;
            if (state_q == S_SORT) begin
                key_q <= key_s;
                pay_q <= pay_s;
                vld_q <= vld_s;
            end else if (do_rep) begin
                // When empty, slot 0 is also the tail, so one write covers both cases.
                key_q[0] <= i_key;
                pay_q[0] <= i_payload;
                vld_q[0] <= 1'b1;
            end else if (do_enq) begin
                for (int i = 0; i < QUEUE_SIZE; i++) begin
                    if (i == int'(count_q)) begin
                        key_q[i] <= i_key;
                        pay_q[i] <= i_payload;
                        vld_q[i] <= 1'b1;
                    end
                end
            end else if (do_deq) begin
                for (int i = 0; i < QUEUE_SIZE-1; i++) begin
                    key_q[i] <= key_q[i+1];
                    pay_q[i] <= pay_q[i+1];
                end
                key_q[QUEUE_SIZE-1] <= '0;
                pay_q[QUEUE_SIZE-1] <= '0;
                vld_q <= {1'b0, vld_q[QUEUE_SIZE-1:1]};
            end

            if (do_enq || (do_rep && empty))
                count_q <= count_q + CW'(1);
            else if (do_deq)
                count_q <= count_q - CW'(1);
        end
    end

    assign o_ready     = accept;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_count     = count_q;
    assign o_valid     = vld_q[0];
    assign o_key       = vld_q[0] ? key_q[0] : '0;
    assign o_payload   = vld_q[0] ? pay_q[0] : '0;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule

// File: tb/tb_register_array_kv.sv
// Directed bench: three queue variants (max-first, min-first/full-length sort, enqueue disabled)
// sharing one request bus; each scenario resets all of them first.
module tb_register_array_kv;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wrt = 1'b0;
    logic        rd  = 1'b0;
    logic [15:0] k   = '0;
    logic [7:0]  p   = '0;

    wire [2:0]       rdy, full, empty, vld, ovf, udf;
    wire [2:0][6:0]  cnt;
    wire [2:0][15:0] key;
    wire [2:0][7:0]  pay;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    register_array_kv #(.QUEUE_SIZE(64), .MAX_FIRST(1), .ENQ_ENA(1), .EARLY_EXIT(1)) u_max (
        .i_CLK(CLK), .i_RST(RST), .i_wrt(wrt), .i_read(rd), .i_key(k), .i_payload(p),
        .o_ready(rdy[0]), .o_full(full[0]), .o_empty(empty[0]), .o_count(cnt[0]),
        .o_valid(vld[0]), .o_key(key[0]), .o_payload(pay[0]),
        .o_overflow(ovf[0]), .o_underflow(udf[0]));

    register_array_kv #(.QUEUE_SIZE(64), .MAX_FIRST(0), .ENQ_ENA(1), .EARLY_EXIT(0)) u_min (
        .i_CLK(CLK), .i_RST(RST), .i_wrt(wrt), .i_read(rd), .i_key(k), .i_payload(p),
        .o_ready(rdy[1]), .o_full(full[1]), .o_empty(empty[1]), .o_count(cnt[1]),
        .o_valid(vld[1]), .o_key(key[1]), .o_payload(pay[1]),
        .o_overflow(ovf[1]), .o_underflow(udf[1]));

    register_array_kv #(.QUEUE_SIZE(64), .MAX_FIRST(1), .ENQ_ENA(0), .EARLY_EXIT(1)) u_noe (
        .i_CLK(CLK), .i_RST(RST), .i_wrt(wrt), .i_read(rd), .i_key(k), .i_payload(p),
        .o_ready(rdy[2]), .o_full(full[2]), .o_empty(empty[2]), .o_count(cnt[2]),
        .o_valid(vld[2]), .o_key(key[2]), .o_payload(pay[2]),
        .o_overflow(ovf[2]), .o_underflow(udf[2]));

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Holds the request for exactly one rising edge; returns at the negedge after it.
    task automatic issue(input logic w, input logic r, input logic [15:0] kk, input logic [7:0] pp);
        @(negedge CLK);
        wrt = w; rd = r; k = kk; p = pp;
        @(negedge CLK);
        wrt = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_ready(input int u, output int busy);
        busy = 0;
        while (rdy[u] !== 1'b1 && busy < 200) begin
            busy++;
            @(negedge CLK);
        end
        checks++;
        if (rdy[u] !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout unit=%0d: o_ready=%b after %0d cycles, required 1", u, rdy[u], busy);
        end
    endtask

    task automatic enq(input int u, input logic [15:0] kk, input logic [7:0] pp, output int busy);
        issue(1'b1, 1'b0, kk, pp);
        wait_ready(u, busy);
    endtask

    task automatic rep(input int u, input logic [15:0] kk, input logic [7:0] pp, output int busy);
        issue(1'b1, 1'b1, kk, pp);
        wait_ready(u, busy);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rdy[0], empty[0], full[0], vld[0], ovf[0], udf[0]} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_flags: rdy/empty/full/vld/ovf/udf=%b, required 110000",
                     {rdy[0], empty[0], full[0], vld[0], ovf[0], udf[0]});
        end
        checks++;
        if (cnt[0] !== 7'd0 || key[0] !== 16'd0 || pay[0] !== 8'd0) begin
            failures++;
            $display("FAIL reset_head: count=%0d key=%0d payload=%0h, required 0 0 0", cnt[0], key[0], pay[0]);
        end
    endtask

    task automatic test_order();
        logic [15:0] ks [4];
        logic [7:0]  ps [4];
        logic [15:0] hs [4];
        logic [15:0] dk [4];
        logic [7:0]  dp [4];
        int busy;
        ks = '{16'd5, 16'd9, 16'd3, 16'd9};
        ps = '{8'h11, 8'hAA, 8'h33, 8'hBB};
        hs = '{16'd5, 16'd9, 16'd9, 16'd9};
        dk = '{16'd9, 16'd9, 16'd5, 16'd3};
        dp = '{8'hAA, 8'hBB, 8'h11, 8'h33};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(0, ks[i], ps[i], busy);
            checks++;
            if (key[0] !== hs[i]) begin
                failures++;
                $display("FAIL order_head[%0d]: key=%0d, required %0d", i, key[0], hs[i]);
            end
        end
        checks++;
        if (cnt[0] !== 7'd4) begin
            failures++;
            $display("FAIL order_count: count=%0d, required 4", cnt[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key[0] !== dk[i] || pay[0] !== dp[i] || rdy[0] !== 1'b1) begin
                failures++;
                $display("FAIL order_drain[%0d]: key=%0d payload=%0h ready=%b, required %0d %0h 1",
                         i, key[0], pay[0], rdy[0], dk[i], dp[i]);
            end
            issue(1'b0, 1'b1, 16'd0, 8'd0);
        end
        checks++;
        if (empty[0] !== 1'b1 || vld[0] !== 1'b0 || key[0] !== 16'd0 || pay[0] !== 8'd0) begin
            failures++;
            $display("FAIL order_empty: empty=%b valid=%b key=%0d payload=%0h, required 1 0 0 0",
                     empty[0], vld[0], key[0], pay[0]);
        end
    endtask

    task automatic test_early_exit();
        int busy;
        do_reset();
        enq(0, 16'd100, 8'h01, busy);
        enq(0, 16'd50, 8'h02, busy);
        enq(0, 16'd10, 8'h03, busy);
        checks++;
        if (busy !== 2 || key[0] !== 16'd100) begin
            failures++;
            $display("FAIL early_exit_min: busy=%0d head=%0d, required 2 100", busy, key[0]);
        end
        enq(0, 16'd200, 8'h04, busy);
        checks++;
        if (busy !== 5 || key[0] !== 16'd200 || pay[0] !== 8'h04) begin
            failures++;
            $display("FAIL early_exit_climb: busy=%0d head=%0d payload=%0h, required 5 200 04",
                     busy, key[0], pay[0]);
        end
    endtask

    task automatic test_overflow();
        int busy;
        do_reset();
        for (int i = 0; i < 64; i++) enq(0, 16'(1000 - i), 8'(i), busy);
        checks++;
        if (full[0] !== 1'b1 || cnt[0] !== 7'd64 || ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, required 1 64 0", full[0], cnt[0], ovf[0]);
        end
        issue(1'b1, 1'b0, 16'd7, 8'h77);
        checks++;
        if (ovf[0] !== 1'b1 || rdy[0] !== 1'b1 || cnt[0] !== 7'd64) begin
            failures++;
            $display("FAIL overflow_pulse: ovf=%b ready=%b count=%0d, required 1 1 64", ovf[0], rdy[0], cnt[0]);
        end
        @(negedge CLK);
        checks++;
        if (ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL overflow_width: ovf=%b one cycle later, required 0", ovf[0]);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (key[0] !== 16'(1000 - i) || pay[0] !== 8'(i)) begin
                failures++;
                $display("FAIL full_contents[%0d]: key=%0d payload=%0h, required %0d %0h",
                         i, key[0], pay[0], 1000 - i, i);
            end
            issue(1'b0, 1'b1, 16'd0, 8'd0);
        end
        checks++;
        if (cnt[0] !== 7'd0 || empty[0] !== 1'b1) begin
            failures++;
            $display("FAIL drain_count: count=%0d empty=%b, required 0 1", cnt[0], empty[0]);
        end
    endtask

    task automatic test_underflow_replace();
        int busy;
        do_reset();
        issue(1'b0, 1'b1, 16'd0, 8'd0);
        checks++;
        if (udf[0] !== 1'b1 || cnt[0] !== 7'd0 || rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL underflow_pulse: udf=%b count=%0d ready=%b, required 1 0 1", udf[0], cnt[0], rdy[0]);
        end
        @(negedge CLK);
        checks++;
        if (udf[0] !== 1'b0) begin
            failures++;
            $display("FAIL underflow_width: udf=%b one cycle later, required 0", udf[0]);
        end
        rep(0, 16'd42, 8'h42, busy);
        checks++;
        if (cnt[0] !== 7'd1 || key[0] !== 16'd42 || vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL replace_empty: count=%0d key=%0d valid=%b, required 1 42 1", cnt[0], key[0], vld[0]);
        end
        enq(0, 16'd30, 8'h30, busy);
        enq(0, 16'd20, 8'h20, busy);
        rep(0, 16'd25, 8'h25, busy);
        checks++;
        if (key[0] !== 16'd30 || cnt[0] !== 7'd3) begin
            failures++;
            $display("FAIL replace_sink: head=%0d count=%0d, required 30 3", key[0], cnt[0]);
        end
        rep(0, 16'd25, 8'hDD, busy);
        checks++;
        if (key[0] !== 16'd25 || pay[0] !== 8'hDD || busy !== 2) begin
            failures++;
            $display("FAIL replace_tie: head=%0d payload=%0h busy=%0d, required 25 dd 2", key[0], pay[0], busy);
        end
    endtask

    task automatic test_no_enq();
        int busy;
        do_reset();
        issue(1'b1, 1'b0, 16'd5, 8'h05);
        checks++;
        if (cnt[2] !== 7'd0 || ovf[2] !== 1'b0 || rdy[2] !== 1'b1 || vld[2] !== 1'b0) begin
            failures++;
            $display("FAIL noenq_ignore: count=%0d ovf=%b ready=%b valid=%b, required 0 0 1 0",
                     cnt[2], ovf[2], rdy[2], vld[2]);
        end
        rep(2, 16'd42, 8'h42, busy);
        checks++;
        if (cnt[2] !== 7'd1 || key[2] !== 16'd42) begin
            failures++;
            $display("FAIL noenq_replace_empty: count=%0d key=%0d, required 1 42", cnt[2], key[2]);
        end
        rep(2, 16'd17, 8'h17, busy);
        checks++;
        if (cnt[2] !== 7'd1 || key[2] !== 16'd17 || pay[2] !== 8'h17) begin
            failures++;
            $display("FAIL noenq_replace: count=%0d key=%0d payload=%0h, required 1 17 17", cnt[2], key[2], pay[2]);
        end
        issue(1'b0, 1'b1, 16'd0, 8'd0);
        checks++;
        if (empty[2] !== 1'b1 || key[2] !== 16'd0) begin
            failures++;
            $display("FAIL noenq_dequeue: empty=%b key=%0d, required 1 0", empty[2], key[2]);
        end
    endtask

    task automatic test_min_reset();
        int busy;
        do_reset();
        enq(1, 16'd30, 8'h30, busy);
        checks++;
        if (busy !== 64) begin
            failures++;
            $display("FAIL full_length_sort: busy=%0d, required 64", busy);
        end
        enq(1, 16'd20, 8'h20, busy);
        enq(1, 16'd10, 8'h10, busy);
        checks++;
        if (key[1] !== 16'd10 || pay[1] !== 8'h10 || cnt[1] !== 7'd3) begin
            failures++;
            $display("FAIL min_first_head: key=%0d payload=%0h count=%0d, required 10 10 3", key[1], pay[1], cnt[1]);
        end
        issue(1'b1, 1'b0, 16'd5, 8'h05);
        repeat (3) @(negedge CLK);
        checks++;
        if (rdy[1] !== 1'b0 || cnt[1] !== 7'd4) begin
            failures++;
            $display("FAIL mid_sort_busy: ready=%b count=%0d, required 0 4", rdy[1], cnt[1]);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({rdy[1], empty[1], full[1], vld[1], ovf[1], udf[1]} !== 6'b110000) begin
            failures++;
            $display("FAIL mid_sort_reset_flags: rdy/empty/full/vld/ovf/udf=%b, required 110000",
                     {rdy[1], empty[1], full[1], vld[1], ovf[1], udf[1]});
        end
        checks++;
        if (cnt[1] !== 7'd0 || key[1] !== 16'd0 || pay[1] !== 8'd0) begin
            failures++;
            $display("FAIL mid_sort_reset_head: count=%0d key=%0d payload=%0h, required 0 0 0", cnt[1], key[1], pay[1]);
        end
        @(negedge CLK);
        RST = 1'b0;
        enq(1, 16'd1, 8'h01, busy);
        checks++;
        if (busy !== 64 || cnt[1] !== 7'd1 || key[1] !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_enqueue: busy=%0d count=%0d key=%0d, required 64 1 1", busy, cnt[1], key[1]);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_early_exit();
        test_overflow();
        test_underflow_replace();
        test_no_enq();
        test_min_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
